fir_1demux4: RTL and testbench

Serial-to-parallel polyphase distributor for the FIR datapath of the DDC chip. It accepts one filter sample per valid cycle, steers consecutive samples into four lanes in rotation, and presents each completed group of four in parallel with a one-cycle valid strobe. It is the write-side counterpart of the 4:1 lane selector. Its lane ordering and 2-bit lane code are identical to that selector (00→a, 01→b, 10→c, 11→d), so a group written here and read back through the selector returns samples in arrival order.

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_1demux4.sv | 72 +++++++
 tb/tb_fir_1demux4.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath: default sample width and the 2-bit
// lane codes common to the 1:4 distributor and the 4:1 lane selector.
package fir_pkg;

    localparam int unsigned FILTERBITWIDTH_DEFAULT = 20;

    localparam logic [1:0] LANE_A = 2'b00;
    localparam logic [1:0] LANE_B = 2'b01;
    localparam logic [1:0] LANE_C = 2'b10;
    localparam logic [1:0] LANE_D = 2'b11;

endpackage : fir_pkg

// File: rtl/fir_1demux4.sv
// Serial-to-parallel polyphase distributor: steers consecutive valid samples
// into lanes a..d and presents each completed group of four in parallel with
// a one-cycle dout_valid strobe. A partial group is never visible on dout_*.
module fir_1demux4
    import fir_pkg::*;
#(
    parameter int unsigned FILTERBITWIDTH = FILTERBITWIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic [FILTERBITWIDTH-1:0] din,
    input  logic                      phase_sync,
    output logic [1:0]                lane_sel,
    output logic [FILTERBITWIDTH-1:0] dout_a,
    output logic [FILTERBITWIDTH-1:0] dout_b,
    output logic [FILTERBITWIDTH-1:0] dout_c,
    output logic [FILTERBITWIDTH-1:0] dout_d,
    output logic                      dout_valid,
    output logic                      sync_err
);

    logic [1:0]                phase;
    logic [FILTERBITWIDTH-1:0] shadow_a;
    logic [FILTERBITWIDTH-1:0] shadow_b;
    logic [FILTERBITWIDTH-1:0] shadow_c;

    assign lane_sel = phase;

    // Phase counter, shadow capture, group load and strobe generation.
    // phase_sync overrides the lane-d wrap/load so a misaligned group is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= LANE_A;
            shadow_a   <= '0;
            shadow_b   <= '0;
            shadow_c   <= '0;
            dout_a     <= '0;
            dout_b     <= '0;
            dout_c     <= '0;
            dout_d     <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_err   <= phase_sync && (phase != LANE_A);
            if (phase_sync) begin
                if (din_valid) begin
                    shadow_a <= din;
                    phase    <= LANE_B;
                end else begin
                    phase    <= LANE_A;
                end
            end else if (din_valid) begin
                case (phase)
                    LANE_A: shadow_a <= din;
                    LANE_B: shadow_b <= din;
                    LANE_C: shadow_c <= din;
                    default: begin
                        dout_a     <= shadow_a;
                        dout_b     <= shadow_b;
                        dout_c     <= shadow_c;
                        dout_d     <= din;
                        dout_valid <= 1'b1;
                    end
                endcase
                phase <= phase + 2'd1;
            end
        end
    end

endmodule : fir_1demux4

// File: tb/tb_fir_1demux4.sv
// Bench for fir_1demux4: a group-level behavioural model (queue of pending
// samples) checked every cycle, plus directed vectors with literal expectations.
module tb_fir_1demux4;
    import fir_pkg::*;

    localparam int unsigned W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         din_valid;
    logic [W-1:0] din;
    logic         phase_sync;
    logic [1:0]   lane_sel;
    logic [W-1:0] dout_a, dout_b, dout_c, dout_d;
    logic         dout_valid;
    logic         sync_err;

    int checks = 0;
    int errors = 0;

    fir_1demux4 #(.FILTERBITWIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .phase_sync (phase_sync),
        .lane_sel   (lane_sel),
        .dout_a     (dout_a),
        .dout_b     (dout_b),
        .dout_c     (dout_c),
        .dout_d     (dout_d),
        .dout_valid (dout_valid),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Model: samples of the current partial group, last emitted group, strobes.
    logic [W-1:0] grp[$];
    logic [W-1:0] m_out[4];
    logic         m_valid;
    logic         m_err;
    logic         model_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            grp.delete();
            for (int i = 0; i < 4; i++) m_out[i] = '0;
            m_valid  = 1'b0;
            m_err    = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_valid = 1'b0;
            m_err   = phase_sync && (grp.size() != 0);
            if (phase_sync) begin
                grp.delete();
                if (din_valid) grp.push_back(din);
            end else if (din_valid) begin
                grp.push_back(din);
                if (grp.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_out[i] = grp[i];
                    m_valid = 1'b1;
                    grp.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_lane_sel", 32'(lane_sel), 32'(grp.size()));
            check("model_dout_a", 32'(dout_a), 32'(m_out[0]));
            check("model_dout_b", 32'(dout_b), 32'(m_out[1]));
            check("model_dout_c", 32'(dout_c), 32'(m_out[2]));
            check("model_dout_d", 32'(dout_d), 32'(m_out[3]));
            check("model_dout_valid", 32'(dout_valid), 32'(m_valid));
            check("model_sync_err", 32'(sync_err), 32'(m_err));
        end
    end

    // One cycle of stimulus; returns 2 time units after the consuming edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic s);
        din_valid  = v;
        din        = d;
        phase_sync = s;
        @(posedge clk);
        #2;
        din_valid  = 1'b0;
        din        = '0;
        phase_sync = 1'b0;
    endtask

    task automatic check_group(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [W-1:0] d);
        check({name, "_a"}, 32'(dout_a), 32'(a));
        check({name, "_b"}, 32'(dout_b), 32'(b));
        check({name, "_c"}, 32'(dout_c), 32'(c));
        check({name, "_d"}, 32'(dout_d), 32'(d));
    endtask

    function automatic logic [W-1:0] sel4(input logic [1:0] s, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c,
                                          input logic [W-1:0] d);
        case (s)
            LANE_A:  return a;
            LANE_B:  return b;
            LANE_C:  return c;
            default: return d;
        endcase
    endfunction

    initial begin
        logic [W-1:0] sent[4];
        rst = 1'b1; din_valid = 1'b0; din = '0; phase_sync = 1'b0;
        step(0, '0, 0);
        step(0, '0, 0);
        rst = 1'b0;
        check("reset_lane_sel", 32'(lane_sel), 0);
        check_group("reset_dout", '0, '0, '0, '0);
        check("reset_valid", 32'(dout_valid), 0);
        check("reset_err", 32'(sync_err), 0);

        // Continuous valid 1..8
        for (int i = 1; i <= 8; i++) begin
            check("cont_lane_sel", 32'(lane_sel), 32'((i - 1) % 4));
            step(1, W'(i), 0);
            check("cont_valid", 32'(dout_valid), (i % 4 == 0) ? 1 : 0);
            if (i == 4) check_group("cont_g1", 1, 2, 3, 4);
        end
        check_group("cont_g2", 5, 6, 7, 8);
        check("cont_wrap_lane", 32'(lane_sel), 0);

        // Gaps stretch the group; prior group held
        step(1, 'h10, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0);
            check("gap_hold_a", 32'(dout_a), 5);
        end
        check("gap_lane_sel", 32'(lane_sel), 1);
        step(1, 'h11, 0);
        step(0, '0, 0);
        step(1, 'h12, 0);
        check("gap_no_valid", 32'(dout_valid), 0);
        step(1, 'h13, 0);
        check("gap_valid", 32'(dout_valid), 1);
        check_group("gap_grp", 'h10, 'h11, 'h12, 'h13);

        // phase_sync with valid at phase 10
        step(1, 'h50, 0);
        step(1, 'h51, 0);
        step(1, 'hA0, 1);
        check("sync_v_err", 32'(sync_err), 1);
        check("sync_v_lane", 32'(lane_sel), 1);
        check("sync_v_valid", 32'(dout_valid), 0);
        step(1, 'hA1, 0);
        check("sync_v_err_clear", 32'(sync_err), 0);
        step(1, 'hA2, 0);
        step(1, 'hA3, 0);
        check("sync_v_out_valid", 32'(dout_valid), 1);
        check_group("sync_v_grp", 'hA0, 'hA1, 'hA2, 'hA3);

        // phase_sync without valid at phase 00 and 11
        step(0, '0, 1);
        check("sync0_err", 32'(sync_err), 0);
        check("sync0_lane", 32'(lane_sel), 0);
        for (int i = 0; i < 3; i++) step(1, W'(32'h60 + i), 0);
        check("sync3_pre_lane", 32'(lane_sel), 3);
        step(0, '0, 1);
        check("sync3_err", 32'(sync_err), 1);
        check("sync3_lane", 32'(lane_sel), 0);
        check("sync3_valid", 32'(dout_valid), 0);

        // phase_sync with valid at phase 11 beats the wrap/load
        for (int i = 0; i < 3; i++) step(1, W'(32'h70 + i), 0);
        step(1, 'hB0, 1);
        check("sync3v_err", 32'(sync_err), 1);
        check("sync3v_valid", 32'(dout_valid), 0);
        check("sync3v_lane", 32'(lane_sel), 1);
        check_group("sync3v_hold", 'hA0, 'hA1, 'hA2, 'hA3);
        for (int i = 1; i < 4; i++) step(1, W'(32'hB0 + i), 0);
        check_group("sync3v_grp", 'hB0, 'hB1, 'hB2, 'hB3);

        // Reset mid-group, then bit-exact extremes
        step(1, 'h90, 0);
        step(1, 'h91, 0);
        rst = 1'b1;
        step(1, 'h92, 1);
        rst = 1'b0;
        check_group("rst_dout", '0, '0, '0, '0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_lane", 32'(lane_sel), 0);
        check("rst_err", 32'(sync_err), 0);
        step(1, 'hFFFFF, 0);
        step(1, 'h80000, 0);
        step(1, 'h00001, 0);
        step(1, 'h7FFFF, 0);
        check("ext_valid", 32'(dout_valid), 1);
        check_group("ext_grp", 'hFFFFF, 'h80000, 'h00001, 'h7FFFF);

        // Loopback through a 4:1 selector over 64 random groups
        for (int g = 0; g < 64; g++) begin
            for (int k = 0; k < 4; k++) begin
                sent[k] = W'($urandom);
                if ($urandom_range(0, 3) == 0) step(0, '0, 0);
                step(1, sent[k], 0);
            end
            check("loop_valid", 32'(dout_valid), 1);
            for (int s = 0; s < 4; s++)
                check("loop_order", 32'(sel4(2'(s), dout_a, dout_b, dout_c, dout_d)), 32'(sent[s]));
        end

        step(0, '0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_fir_1demux4
